core_block_loader: RTL

CORE_BLOCK_LOADER -- requirements
Module: core_block_loader

---
 rtl/core_block_loader_if.sv | 33 +++
 rtl/core_block_loader.sv | 80 ++++++++
 2 files changed

// File: rtl/core_block_loader_if.sv
// Bundle between the memory manager / hash engine (master) and the block loader (slave).
// Carries block-word shifting, the assembled block, and the solution-claim handshake.
interface core_block_loader_if #(
  parameter int DATAWIDTH = 32,
  parameter int NWORDS    = 24
);
  logic                              start_in;
  logic                              shift_in_enable;
  logic [DATAWIDTH-1:0]              data_in;
  logic [8*DATAWIDTH-1:0]            mid_state;
  logic [(NWORDS-8)*DATAWIDTH-1:0]   head_data;
  logic                              block_valid;
  logic                              block_load;
  logic [4:0]                        word_count;
  logic                              nonce_valid;
  logic [DATAWIDTH-1:0]              nonce_in;
  logic                              sol_claim;
  logic [DATAWIDTH-1:0]              nonce_out;
  logic                              sol_response;
  logic                              protocol_err;

  modport master (
    output start_in, shift_in_enable, data_in, nonce_valid, nonce_in, sol_response,
    input  mid_state, head_data, block_valid, block_load, word_count,
           sol_claim, nonce_out, protocol_err
  );

  modport slave (
    input  start_in, shift_in_enable, data_in, nonce_valid, nonce_in, sol_response,
    output mid_state, head_data, block_valid, block_load, word_count,
           sol_claim, nonce_out, protocol_err
  );
endinterface

// File: rtl/core_block_loader.sv
// Assembles midstate + header words into a block and runs a one-claim-per-block nonce handshake.
// Block outputs update one cycle after the triggering shift; sol_claim is decoded from the CLAIM state.
module core_block_loader #(
  parameter int DATAWIDTH = 32,
  parameter int NWORDS    = 24
) (
  input logic               clk,
  input logic               reset,
  core_block_loader_if.slave bus
);
  localparam int         MID_WORDS  = 8;
  localparam int         HEAD_WORDS = NWORDS - MID_WORDS;
  localparam logic [4:0] LAST_IDX   = 5'(NWORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, READY, CLAIM, DONE} state_t;
  state_t state;

  // A claim in flight always completes, so start_in has no effect in CLAIM.
  logic restart;
  assign restart = bus.start_in && (state != CLAIM);

  assign bus.sol_claim = (state == CLAIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      bus.mid_state    <= '0;
      bus.head_data    <= '0;
      bus.word_count   <= '0;
      bus.nonce_out    <= '0;
      bus.block_valid  <= 1'b0;
      bus.block_load   <= 1'b0;
      bus.protocol_err <= 1'b0;
    end else begin
      bus.block_load <= 1'b0;
      if (restart) begin
        state            <= LOAD;
        bus.word_count   <= '0;
        bus.block_valid  <= 1'b0;
        bus.protocol_err <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (bus.shift_in_enable) begin
              for (int i = 0; i < MID_WORDS; i++) begin
                if (bus.word_count == 5'(i))
                  bus.mid_state[i*DATAWIDTH +: DATAWIDTH] <= bus.data_in;
              end
              for (int i = 0; i < HEAD_WORDS; i++) begin
                if (bus.word_count == 5'(i + MID_WORDS))
                  bus.head_data[i*DATAWIDTH +: DATAWIDTH] <= bus.data_in;
              end
              bus.word_count <= bus.word_count + 5'd1;
              if (bus.word_count == LAST_IDX) begin
                state           <= READY;
                bus.block_valid <= 1'b1;
                bus.block_load  <= 1'b1;
              end
            end
          end
          READY: begin
            if (bus.nonce_valid) begin
              bus.nonce_out <= bus.nonce_in;
              state         <= CLAIM;
            end
            if (bus.shift_in_enable) bus.protocol_err <= 1'b1;
          end
          CLAIM: begin
            if (bus.sol_response) state <= DONE;
            if (bus.shift_in_enable) bus.protocol_err <= 1'b1;
          end
          IDLE, DONE: begin
            if (bus.shift_in_enable) bus.protocol_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
